// File: rtl/rom_arbiter_pkg.sv
// Shared encodings for the ROM arbiter slice: load sizes, FSM states and
// the core-wide constants that other blocks also pull from here.
package rom_arbiter_pkg;

    // Core-wide constants
    localparam int          MEM_ADDR_BUS = 32;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    // LS access size encodings (3 is illegal)
    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    // Arbiter FSM: idle, or holding a response for one of the two ports
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_LS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/response bundle between the core's IF/LS stages and the arbiter.
// The core side is the master, the arbiter is the slave.
interface rom_arbiter_if #(
    parameter int ADDR_W = rom_arbiter_pkg::MEM_ADDR_BUS
);
    // Instruction fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              if_rready_i;

    // Load/store read-only port
    logic              ls_req_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [1:0]        ls_size_i;
    logic              ls_unsigned_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [31:0]       ls_rdata_o;
    logic              ls_err_o;
    logic              ls_rready_i;

    modport master (
        output if_req_i, if_addr_i, if_rready_i,
        output ls_req_i, ls_addr_i, ls_size_i, ls_unsigned_i, ls_rready_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o
    );

    modport slave (
        input  if_req_i, if_addr_i, if_rready_i,
        input  ls_req_i, ls_addr_i, ls_size_i, ls_unsigned_i, ls_rready_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o
    );

endinterface

// File: rtl/rom_load_align.sv
// Combinational lane select and sign/zero extension for LS loads out of a
// big-endian ROM word (byte offset 0 lives in [31:24]), plus the
// misalignment / illegal-size check. Erroring loads return zero data.
module rom_load_align
    import rom_arbiter_pkg::*;
(
    input  logic [31:0] rom_data_i,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data,
    output logic        err
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/half, then extend or flag the access
    always_comb begin
        lane_b = 8'd0;
        unique case (off)
            2'd0: lane_b = rom_data_i[31:24];
            2'd1: lane_b = rom_data_i[23:16];
            2'd2: lane_b = rom_data_i[15:8];
            2'd3: lane_b = rom_data_i[7:0];
        endcase
        lane_h = off[1] ? rom_data_i[15:0] : rom_data_i[31:16];

        data = 32'd0;
        err  = 1'b0;
        case (size)
            LS_BYTE: data = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            LS_HALF: begin
                if (off[0]) err  = 1'b1;
                else        data = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            LS_WORD: begin
                if (off != 2'd0) err  = 1'b1;
                else             data = rom_data_i;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port instruction ROM between instruction fetch and
// read-only LS loads. LS normally wins; after STARVE_N LS grants with IF
// waiting, IF is forced through. Each grant yields exactly one registered
// response one cycle later, held until the owning port takes it.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_BUS,
    parameter int STARVE_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    rom_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i
);

    // Sized so the counter can always reach STARVE_N, even for STARVE_N = 0
    localparam int                CNT_W      = $clog2(STARVE_N + 2);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_N);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    arb_state_e        state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              if_rvalid_q, ls_rvalid_q, ls_err_q;
    logic [31:0]       if_rdata_q, ls_rdata_q;

    logic              eligible, if_win, ls_win;
    logic [31:0]       ld_data;
    logic              ld_err;

    // Grant only when the response slot is free or being freed this cycle
    always_comb begin
        eligible = (state == IDLE)
                 | ((state == RSP_IF) & bus.if_rready_i)
                 | ((state == RSP_LS) & bus.ls_rready_i);
        ls_win   = eligible & bus.ls_req_i
                 & ~(bus.if_req_i & (starve_cnt == STARVE_MAX));
        if_win   = eligible & bus.if_req_i & ~ls_win;
    end

    // ROM address follows the winner in the grant cycle, otherwise holds
    always_comb begin
        rom_addr_o = addr_q;
        if (ls_win)      rom_addr_o = bus.ls_addr_i & WORD_MASK;
        else if (if_win) rom_addr_o = bus.if_addr_i & WORD_MASK;
    end

    rom_load_align u_align (
        .rom_data_i (rom_data_i),
        .off        (bus.ls_addr_i[1:0]),
        .size       (bus.ls_size_i),
        .uns        (bus.ls_unsigned_i),
        .data       (ld_data),
        .err        (ld_err)
    );

    // FSM, response registers, held ROM address and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            addr_q      <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            ls_rdata_q  <= 32'd0;
        end else begin
            if (if_win)
                starve_cnt <= '0;
            else if (ls_win && bus.if_req_i && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + CNT_W'(1);

            if (ls_win || if_win)
                addr_q <= rom_addr_o;

            // Outside an eligible cycle the current response is still pending
            if (eligible) begin
                if (ls_win) begin
                    state       <= RSP_LS;
                    ls_rvalid_q <= 1'b1;
                    if_rvalid_q <= 1'b0;
                    ls_rdata_q  <= ld_data;
                    ls_err_q    <= ld_err;
                end else if (if_win) begin
                    state       <= RSP_IF;
                    if_rvalid_q <= 1'b1;
                    ls_rvalid_q <= 1'b0;
                    if_rdata_q  <= rom_data_i;
                end else begin
                    state       <= IDLE;
                    if_rvalid_q <= 1'b0;
                    ls_rvalid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.if_gnt_o    = if_win;
    assign bus.ls_gnt_o    = ls_win;
    assign bus.if_rvalid_o = if_rvalid_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.ls_rvalid_o = ls_rvalid_q;
    assign bus.ls_rdata_o  = ls_rdata_q;
    assign bus.ls_err_o    = ls_err_q;

endmodule
